ps2_key_tracker: RTL and testbench

//  Parametrised PS/2 keyboard receiver and key-state tracker for the game controls.

---
 rtl/ps2_key_tracker.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with a held/released state table for NUM_KEYS scan codes.
// Optional build macro PS2_EXT_CODE_EN enables E0-prefixed (extended) key matching.
module ps2_key_tracker #(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = {8'h5A, 8'h23, 8'h1C, 8'h1D},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
    parameter int                      TIMEOUT_CYCLES = 50000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [7:0]          scan_code,
    output logic                scan_valid,
    output logic                frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            clk_s_q;
    logic [1:0]            dat_s_q;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  brk_q, brk_d;
    logic [NUM_KEYS-1:0]   down_q, down_d;
    logic [NUM_KEYS-1:0]   press_q, press_d;
    logic [NUM_KEYS-1:0]   rel_q, rel_d;
    logic [7:0]            code_q, code_d;
    logic                  sv_q, ferr_q;

    logic                  fall, dat;
    logic                  byte_ok, err;
    logic                  ext_v, is_e0;
    logic                  hit;
    logic [IW-1:0]         idx;

    assign fall = clk_s_q[2] & ~clk_s_q[1];
    assign dat  = dat_s_q[1];

    // Synchronisers idle high to match the PS/2 bus idle level.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clk_s_q <= 3'b111;
            dat_s_q <= 2'b11;
        end else begin
            clk_s_q <= {clk_s_q[1:0], PS2_CLK};
            dat_s_q <= {dat_s_q[0], PS2_DAT};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_d      = to_q;
        byte_ok   = 1'b0;
        err       = 1'b0;
        if (fall) begin
            to_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat && (^{shift_q, par_q})) byte_ok = 1'b1;
                    else                            err     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_q == TO_MAX) begin
                state_d = IDLE;
                err     = 1'b1;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_q      <= to_d;
        end
    end

`ifdef PS2_EXT_CODE_EN
    localparam logic [NUM_KEYS-1:0] EXT_SEL = KEY_EXT;
    logic ext_q, ext_d;

    always_comb begin
        ext_d = ext_q;
        if (err) begin
            ext_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == 8'hE0)      ext_d = 1'b1;
            else if (shift_q != 8'hF0) ext_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) ext_q <= 1'b0;
        else         ext_q <= ext_d;
    end

    assign ext_v = ext_q;
    assign is_e0 = (shift_q == 8'hE0);
`else
    // Entries match on code alone; the mask folds to zero.
    localparam logic [NUM_KEYS-1:0] EXT_SEL = KEY_EXT & '0;
    assign ext_v = 1'b0;
    assign is_e0 = 1'b0;
`endif

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (shift_q == KEY_CODES[8*i +: 8] && ext_v == EXT_SEL[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

    always_comb begin
        down_d  = down_q;
        press_d = '0;
        rel_d   = '0;
        brk_d   = brk_q;
        code_d  = code_q;
        if (err) brk_d = 1'b0;
        if (byte_ok) begin
            code_d = shift_q;
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (!is_e0) begin
                brk_d = 1'b0;
                if (hit) begin
                    if (brk_q) begin
                        down_d[idx] = 1'b0;
                        rel_d[idx]  = down_q[idx];
                    end else begin
                        down_d[idx]  = 1'b1;
                        press_d[idx] = ~down_q[idx];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            brk_q   <= 1'b0;
            down_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            code_q  <= '0;
            sv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            brk_q   <= brk_d;
            down_q  <= down_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            code_q  <= code_d;
            sv_q    <= byte_ok;
            ferr_q  <= err;
        end
    end

    assign key_down    = down_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign scan_code   = code_q;
    assign scan_valid  = sv_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed PS/2 frames, queued expected events.
`timescale 1ns/1ps
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_clk, ps2_dat;
    logic [3:0] key_down, key_press, key_release;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    typedef struct packed {
        logic       sv;
        logic       fe;
        logic [7:0] code;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] dn;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    ps2_key_tracker dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_err   (frame_err)
    );

    // Monitor: every cycle with any pulse must match the head of the queue.
    always @(negedge clk) begin
        ev_t obs, e;
        if (resetn && (scan_valid || frame_err || (|key_press) || (|key_release))) begin
            obs = '{scan_valid, frame_err, scan_code, key_press, key_release, key_down};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event got=%h required=none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL event got=%h required=%h", obs, e);
                end
            end
        end
    end

    task automatic expect_ev(input logic sv, input logic fe, input logic [7:0] code,
                             input logic [3:0] pr, input logic [3:0] rl,
                             input logic [3:0] dn);
        exp_q.push_back('{sv, fe, code, pr, rl, dn});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] d, input logic [3:0] pr,
                        input logic [3:0] rl, input logic [3:0] dn);
        expect_ev(1'b1, 1'b0, d, pr, rl, dn);
        send(d, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] part;
        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({key_down, key_press, key_release, scan_code,
                                  scan_valid, frame_err}), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Make then break of key 1
        good(8'h1C, 4'b0010, 4'b0000, 4'b0010);
        good(8'hF0, 4'b0000, 4'b0000, 4'b0010);
        good(8'h1C, 4'b0000, 4'b0010, 4'b0000);
        chk("t1_down", 32'(key_down), 32'h0);

        // Typematic repeats: one press pulse only
        good(8'h23, 4'b0100, 4'b0000, 4'b0100);
        good(8'h23, 4'b0000, 4'b0000, 4'b0100);
        good(8'h23, 4'b0000, 4'b0000, 4'b0100);

        // Bad parity, then bad stop
        expect_ev(1'b0, 1'b1, 8'h23, 4'b0000, 4'b0000, 4'b0100);
        send(8'h5A, 1'b1, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h23, 4'b0000, 4'b0000, 4'b0100);
        send(8'h5A, 1'b0, 1'b1);
        chk("t3_down", 32'(key_down), 32'h4);

        // Timeout in the middle of a frame
        part = 8'h1D;
        expect_ev(1'b0, 1'b1, 8'h23, 4'b0000, 4'b0000, 4'b0100);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        ps2_dat = 1'b1;
        repeat (50100) @(negedge clk);
        chk("t4_timeout_seen", 32'(exp_q.size()), 32'd0);
        good(8'h1D, 4'b0001, 4'b0000, 4'b0101);

        // E0 is an ordinary byte in the default build
        good(8'hE0, 4'b0000, 4'b0000, 4'b0101);
        good(8'h1C, 4'b0010, 4'b0000, 4'b0111);

        // Reach key_down = 1001
        good(8'hF0, 4'b0000, 4'b0000, 4'b0111);
        good(8'h23, 4'b0000, 4'b0100, 4'b0011);
        good(8'hF0, 4'b0000, 4'b0000, 4'b0011);
        good(8'h1C, 4'b0000, 4'b0010, 4'b0001);
        good(8'h5A, 4'b1000, 4'b0000, 4'b1001);
        chk("t6_pre_down", 32'(key_down), 32'h9);

        // Reset during the 5th data bit
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        @(negedge clk);
        ps2_dat = part[4];
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("t6_reset_outputs", 32'({key_down, key_press, key_release, scan_code,
                                     scan_valid, frame_err}), 32'd0);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
        good(8'h1C, 4'b0010, 4'b0000, 4'b0010);
        chk("t6_post_down", 32'(key_down), 32'h2);

        repeat (50) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
